// File: rtl/miriscv_data_mem_responder.sv
// Data-memory responder for the core's LSU: word-organised single-port SRAM, byte-enable stores,
// fixed response latency. Define MIRISCV_DMEM_STALL_EN to add 0..3 LFSR-chosen extra wait cycles.
module miriscv_data_mem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          we_reg, we_next;
    logic          inr_reg, inr_next;
    logic          err_reg, err_next;
    logic [31:0]   hold_reg, hold_next;

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          accept;
    logic [31:0]   rd_word;
    logic [31:0]   resp_data;
    logic [1:0]    extra;
    logic [CW-1:0] total_lat;
    logic [1:0]    unused_offset;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign offset        = data_addr_i - BASE_ADDR;
    assign word_idx      = offset[AW+1:2];
    assign in_range      = (offset[31:AW+2] == '0);
    assign unused_offset = offset[1:0];
    assign accept        = (state_reg == IDLE) && data_req_i;

`ifdef MIRISCV_DMEM_STALL_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign extra = lfsr_reg[1:0];
`else
    assign extra = 2'd0;
`endif

    assign total_lat = CW'(LATENCY) + CW'(extra);

    // One RAM per byte lane keeps byte-enable writes a plain single-port write per lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk_i) begin
                if (accept && in_range && data_we_i && data_be_i[gi]) begin
                    lane_mem[word_idx] <= data_wdata_i[gi*8 +: 8];
                end
                if (accept && in_range && !data_we_i) begin
                    lane_rd_reg <= lane_mem[word_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    assign resp_data  = (we_reg || !inr_reg) ? 32'h0 : rd_word;
    assign data_err_o = err_reg;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            inr_reg   <= 1'b0;
            err_reg   <= 1'b0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            inr_reg   <= inr_next;
            err_reg   <= err_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        we_next       = we_reg;
        inr_next      = inr_reg;
        err_next      = err_reg;
        hold_next     = hold_reg;
        data_rvalid_o = 1'b0;
        data_rdata_o  = hold_reg;

        case (state_reg)
            IDLE: begin
                if (data_req_i) begin
                    we_next  = data_we_i;
                    inr_next = in_range;
                    if (!in_range) begin
                        err_next = 1'b1;
                    end
                    if (total_lat == CW'(1)) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = total_lat - CW'(2);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            RESP: begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = resp_data;
                hold_next     = resp_data;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
